// File: rtl/coherent_averager_pkg.sv
// Shared types and helpers for the coherent averager: FSM state encoding and
// the points-per-cycle clamp used when a run's configuration is latched.
package coherent_avg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCUM   = 2'd1,
      ST_READOUT = 2'd2,
      ST_DONE    = 2'd3
   } avg_state_t;

   localparam int MIN_PTS = 2;

   function automatic logic [16:0] clamp_pts(input logic [15:0] val,
                                             input logic [16:0] lo,
                                             input logic [16:0] hi);
      logic [16:0] v;
      v = {1'b0, val};
      if (v < lo)
         return lo;
      else if (v > hi)
         return hi;
      else
         return v;
   endfunction

endpackage

// File: rtl/coherent_averager_if.sv
// Sample stream into the averager and accumulated-sum stream out of it.
interface coherent_averager_if #(
   parameter int DATA_W = 14,
   parameter int ACC_W  = 32
);
   import coherent_avg_pkg::*;

   logic [DATA_W-1:0] data_in;
   logic              data_in_valid;
   logic [ACC_W-1:0]  data_out;
   logic              data_out_valid;

   modport master (
      output data_in,
      output data_in_valid,
      input  data_out,
      input  data_out_valid
   );

   modport slave (
      input  data_in,
      input  data_in_valid,
      output data_out,
      output data_out_valid
   );

endinterface

// File: rtl/coherent_averager_ram.sv
// Simple dual-port accumulation buffer: one write port, one registered read port.
module avg_sdp_ram
   import coherent_avg_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clock) begin
      if (we)
         mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/coherent_averager.sv
// Coherent averager: sums N cycles of P points into a buffer, then streams the P sums.
// Optional COHERENT_AVG_SHIFT_EN adds a per-run arithmetic right shift of the output.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for enable; configuration latched on exit
// ST_ACCUM   | read-modify-write of one buffer entry per valid sample
// ST_READOUT | buffer streamed out, one word per clock
// ST_DONE    | one-clock done pulse, then back to idle
module coherent_averager
   import coherent_avg_pkg::*;
#(
   parameter int DATA_W = 14,
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 10
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [15:0]         ptos_x_ciclo,
   input  logic [15:0]         ciclos_a_promediar,
`ifdef COHERENT_AVG_SHIFT_EN
   input  logic [4:0]          shift_out,
`endif
   coherent_averager_if.slave  bus,
   output logic                busy,
   output logic                done
);

   localparam int MAX_PTS = 2**ADDR_W;

   avg_state_t        state;
   avg_state_t        state_nx;

   logic [ADDR_W-1:0] k;
   logic [ADDR_W-1:0] p_last;
   logic [15:0]       cyc_left;
   logic              first_cyc;
   logic              acc_last;
   logic              rd_active;

   logic [16:0]       p_eff_c;
   logic [ADDR_W-1:0] p_last_c;
   logic [15:0]       n_last_c;

   logic              start;
   logic              accept;
   logic              rd_go;

   logic              s0_valid;
   logic              s0_first;
   logic [ADDR_W-1:0] s0_addr;
   logic [DATA_W-1:0] s0_data;

   logic              ram_we;
   logic [ACC_W-1:0]  ram_wdata;
   logic [ACC_W-1:0]  ram_rdata;

   logic              p1_valid;
   logic              p1_last;
   logic              src_valid;
   logic              src_last;
   logic [ACC_W-1:0]  src_data;
   logic              out_last;

   assign p_eff_c  = clamp_pts(ptos_x_ciclo, 17'(MIN_PTS), 17'(MAX_PTS));
   assign p_last_c = ADDR_W'(p_eff_c - 17'd1);
   assign n_last_c = (ciclos_a_promediar == 16'd0) ? 16'd0 : ciclos_a_promediar - 16'd1;

   assign start  = (state == ST_IDLE) && enable;
   assign accept = (state == ST_ACCUM) && enable && bus.data_in_valid && !acc_last;
   assign rd_go  = (state == ST_READOUT) && enable;

   assign busy = (state == ST_ACCUM) || (state == ST_READOUT);
   assign done = (state == ST_DONE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:    if (enable) state_nx = ST_ACCUM;
         ST_ACCUM:   if (!enable) state_nx = ST_IDLE;
                     else if (acc_last) state_nx = ST_READOUT;
         ST_READOUT: if (!enable) state_nx = ST_IDLE;
                     else if (out_last) state_nx = ST_DONE;
         ST_DONE:    state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // k addresses the buffer in both phases; it has wrapped to 0 when readout begins.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         k         <= '0;
         p_last    <= '0;
         cyc_left  <= '0;
         first_cyc <= 1'b0;
         acc_last  <= 1'b0;
         rd_active <= 1'b0;
      end else if (start) begin
         k         <= '0;
         p_last    <= p_last_c;
         cyc_left  <= n_last_c;
         first_cyc <= 1'b1;
         acc_last  <= 1'b0;
         rd_active <= 1'b0;
      end else if (accept) begin
         if (k == p_last) begin
            k         <= '0;
            first_cyc <= 1'b0;
            if (cyc_left == 16'd0)
               acc_last <= 1'b1;
            else
               cyc_left <= cyc_left - 16'd1;
         end else begin
            k <= k + 1'b1;
         end
      end else if ((state == ST_ACCUM) && acc_last && enable) begin
         rd_active <= 1'b1;
      end else if (rd_go && rd_active) begin
         if (k == p_last) begin
            k         <= '0;
            rd_active <= 1'b0;
         end else begin
            k <= k + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s0_valid <= 1'b0;
         s0_first <= 1'b0;
         s0_addr  <= '0;
         s0_data  <= '0;
      end else begin
         s0_valid <= accept;
         if (accept) begin
            s0_first <= first_cyc;
            s0_addr  <= k;
            s0_data  <= bus.data_in;
         end
      end
   end

   // First cycle overwrites the entry, so stale data from a previous run never leaks in.
   assign ram_we    = s0_valid && (state == ST_ACCUM) && enable;
   assign ram_wdata = (s0_first ? '0 : ram_rdata)
                      + {{(ACC_W-DATA_W){s0_data[DATA_W-1]}}, s0_data};

   avg_sdp_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (ACC_W)
   ) u_ram (
      .clock (clock),
      .we    (ram_we),
      .waddr (s0_addr),
      .wdata (ram_wdata),
      .raddr (k),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         p1_valid <= 1'b0;
         p1_last  <= 1'b0;
      end else begin
         p1_valid <= rd_go && rd_active;
         p1_last  <= rd_go && rd_active && (k == p_last);
      end
   end

`ifdef COHERENT_AVG_SHIFT_EN
   logic [4:0]       shift_r;
   logic             p2_valid;
   logic             p2_last;
   logic [ACC_W-1:0] p2_data;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shift_r  <= '0;
         p2_valid <= 1'b0;
         p2_last  <= 1'b0;
         p2_data  <= '0;
      end else begin
         if (start)
            shift_r <= shift_out;
         p2_valid <= rd_go && p1_valid;
         p2_last  <= rd_go && p1_last;
         p2_data  <= $signed(ram_rdata) >>> shift_r;
      end
   end

   assign src_valid = p2_valid;
   assign src_last  = p2_last;
   assign src_data  = p2_data;
`else
   assign src_valid = p1_valid;
   assign src_last  = p1_last;
   assign src_data  = ram_rdata;
`endif

   // An abort clears the output stage on the same edge the FSM returns to idle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.data_out       <= '0;
         bus.data_out_valid <= 1'b0;
         out_last           <= 1'b0;
      end else begin
         bus.data_out_valid <= rd_go && src_valid;
         out_last           <= rd_go && src_valid && src_last;
         if (rd_go && src_valid)
            bus.data_out <= src_data;
      end
   end

endmodule
